// File: rtl/icache_refill_unit.sv
// Single-outstanding instruction-cache miss handler: latches the miss and victim way,
// fetches the line beat by beat into a line buffer, then installs data and tag in one write.
module icache_refill_unit #(
   parameter  int DEPTH       = 256,
   parameter  int WAY_NUM     = 4,
   parameter  int PADDR_WIDTH = 32,
   parameter  int LINE_BYTES  = 32,
   parameter  int DATA_WIDTH  = 64,
   localparam int SET_WIDTH   = $clog2(DEPTH),
   localparam int WAY_WIDTH   = $clog2(WAY_NUM),
   localparam int OFF_WIDTH   = $clog2(LINE_BYTES),
   localparam int TAG_WIDTH   = PADDR_WIDTH - SET_WIDTH - OFF_WIDTH,
   localparam int LINE_WIDTH  = LINE_BYTES * 8,
   localparam int BEATS       = LINE_WIDTH / DATA_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   miss_valid,
   input  logic [PADDR_WIDTH-1:0] miss_addr,
   output logic                   miss_ready,
   input  logic [WAY_WIDTH-1:0]   miss_way,
   input  logic                   flush,
   output logic                   req_valid,
   input  logic                   req_ready,
   output logic [PADDR_WIDTH-1:0] req_addr,
   input  logic                   rsp_valid,
   input  logic [DATA_WIDTH-1:0]  rsp_data,
   output logic                   wr_en,
   output logic [SET_WIDTH-1:0]   wr_idx,
   output logic [WAY_WIDTH-1:0]   wr_way,
   output logic [TAG_WIDTH-1:0]   wr_tag,
   output logic [LINE_WIDTH-1:0]  wr_data,
   output logic                   refill_done
);

   localparam int                    CNT_WIDTH = $clog2(BEATS);
   localparam int                    LINE_AW   = PADDR_WIDTH - OFF_WIDTH;
   localparam logic [CNT_WIDTH-1:0]  LAST_CNT  = CNT_WIDTH'(BEATS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_FILL,
      S_WRITE,
      S_DRAIN
   } state_t;

   state_t                               state_q, state_d;
   logic [LINE_AW-1:0]                   line_q;
   logic [WAY_WIDTH-1:0]                 way_q;
   logic [CNT_WIDTH-1:0]                 cnt_q;
   logic [BEATS-1:0][DATA_WIDTH-1:0]     buf_q;

   logic accept;
   logic last_beat;
   logic count_beat;
   logic store_beat;
   logic unused_off;

   // Byte offset of the miss is irrelevant: the whole line is refilled.
   assign unused_off = ^miss_addr[OFF_WIDTH-1:0];

   assign accept     = (state_q == S_IDLE) && miss_valid && !flush;
   assign last_beat  = (cnt_q == LAST_CNT);
   assign count_beat = rsp_valid && ((state_q == S_FILL) || (state_q == S_DRAIN));
   assign store_beat = rsp_valid && !flush && (state_q == S_FILL);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A flush on the final beat leaves nothing to drain, so it returns straight to idle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (miss_valid && !flush) state_d = S_REQ;
         end
         S_REQ: begin
            if (req_ready)  state_d = flush ? S_DRAIN : S_FILL;
            else if (flush) state_d = S_IDLE;
         end
         S_FILL: begin
            if (flush)                       state_d = (rsp_valid && last_beat) ? S_IDLE : S_DRAIN;
            else if (rsp_valid && last_beat) state_d = S_WRITE;
         end
         S_DRAIN: begin
            if (rsp_valid && last_beat) state_d = S_IDLE;
         end
         S_WRITE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      miss_ready  = 1'b0;
      req_valid   = 1'b0;
      wr_en       = 1'b0;
      refill_done = 1'b0;
      case (state_q)
         S_IDLE:  miss_ready = 1'b1;
         S_REQ:   req_valid  = 1'b1;
         S_WRITE: begin
            wr_en       = 1'b1;
            refill_done = 1'b1;
         end
         default: ;
      endcase
   end

   // Beat counter saturates at the last beat so it never wraps inside one refill.
   always_ff @(posedge clk) begin
      if (rst) begin
         line_q <= '0;
         way_q  <= '0;
         cnt_q  <= '0;
         buf_q  <= '0;
      end else begin
         if (accept) begin
            line_q <= miss_addr[PADDR_WIDTH-1:OFF_WIDTH];
            way_q  <= miss_way;
            cnt_q  <= '0;
         end else if (count_beat && !last_beat) begin
            cnt_q  <= cnt_q + CNT_WIDTH'(1);
         end
         if (store_beat) buf_q[cnt_q] <= rsp_data;
      end
   end

   assign req_addr = {line_q, {OFF_WIDTH{1'b0}}};
   assign wr_idx   = line_q[SET_WIDTH-1:0];
   assign wr_tag   = line_q[LINE_AW-1:SET_WIDTH];
   assign wr_way   = way_q;
   assign wr_data  = buf_q;

`ifndef SYNTHESIS
   // Memory must not return beats while no line request is outstanding.
   assert property (@(posedge clk) disable iff (rst)
      !(rsp_valid && ((state_q == S_IDLE) || (state_q == S_REQ))))
      else $error("icache_refill_unit: response beat with no outstanding request");
`endif

endmodule

// File: tb/tb_icache_refill_unit.sv
// Bench for icache_refill_unit: table-driven refills, hand-written flush/reset sequences,
// and randomized refills checked against expectations derived from address arithmetic.
module tb_icache_refill_unit;

   logic         clk = 1'b0;
   logic         rst;
   logic         miss_valid;
   logic [31:0]  miss_addr;
   logic         miss_ready;
   logic [1:0]   miss_way;
   logic         flush;
   logic         req_valid;
   logic         req_ready;
   logic [31:0]  req_addr;
   logic         rsp_valid;
   logic [63:0]  rsp_data;
   logic         wr_en;
   logic [7:0]   wr_idx;
   logic [1:0]   wr_way;
   logic [18:0]  wr_tag;
   logic [255:0] wr_data;
   logic         refill_done;

   int n_checks = 0;
   int n_errors = 0;
   int tog_idx  = 1;
   logic [1:0] tog_seq [3];

   icache_refill_unit dut (
      .clk         (clk),
      .rst         (rst),
      .miss_valid  (miss_valid),
      .miss_addr   (miss_addr),
      .miss_ready  (miss_ready),
      .miss_way    (miss_way),
      .flush       (flush),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .wr_en       (wr_en),
      .wr_idx      (wr_idx),
      .wr_way      (wr_way),
      .wr_tag      (wr_tag),
      .wr_data     (wr_data),
      .refill_done (refill_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]      addr;
      logic [1:0]       way;
      logic [3:0][63:0] beats;
      int               stall;
      int               gap;
      int               flush_beat;
      bit               tog;
      logic [31:0]      exp_req;
      logic [7:0]       exp_idx;
      logic [18:0]      exp_tag;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance one clock; outputs are observed 1ns after the edge.
   task automatic tick(input bit tog);
      @(posedge clk);
      #1;
      miss_addr = $urandom;
      if (tog) begin
         miss_way = tog_seq[tog_idx];
         tog_idx  = (tog_idx + 1) % 3;
      end else begin
         miss_way = 2'($urandom);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_miss_ready"},  miss_ready,  1);
      check({tag, "_req_valid"},   req_valid,   0);
      check({tag, "_wr_en"},       wr_en,       0);
      check({tag, "_refill_done"}, refill_done, 0);
      check({tag, "_wr_way"},      wr_way,      0);
      check({tag, "_wr_idx"},      wr_idx,      0);
      check({tag, "_wr_tag"},      wr_tag,      0);
      check({tag, "_wr_data"},     wr_data,     0);
      check({tag, "_req_addr"},    req_addr,    0);
   endtask

   task automatic accept_miss(input logic [31:0] addr, input logic [1:0] way);
      check("accept_miss_ready", miss_ready, 1);
      miss_valid = 1'b1;
      miss_addr  = addr;
      miss_way   = way;
      tick(1'b0);
      miss_valid = 1'b0;
      check("accept_req_valid", req_valid, 1);
   endtask

   // Feed n beats that must never produce a write; idle must follow the final one.
   task automatic drain_beats(input int n, input string tag);
      for (int k = 0; k < n; k++) begin
         rsp_valid = 1'b1;
         rsp_data  = {$urandom, $urandom};
         tick(1'b0);
         rsp_valid = 1'b0;
         check({tag, "_no_wr"},   wr_en,       0);
         check({tag, "_no_done"}, refill_done, 0);
         check({tag, "_ready"},   miss_ready,  (k == n - 1) ? 1 : 0);
      end
      tick(1'b0);
      check({tag, "_after_no_wr"}, wr_en, 0);
   endtask

   task automatic do_refill(input logic [31:0] addr, input logic [1:0] way,
                            input logic [3:0][63:0] beats, input int stall, input int gap,
                            input int flush_beat, input bit tog, input logic [31:0] exp_req,
                            input logic [7:0] exp_idx, input logic [18:0] exp_tag);
      logic [255:0] exp_line;
      bit           flushed;
      exp_line = beats;
      flushed  = (flush_beat >= 0);
      check("idle_miss_ready", miss_ready, 1);
      miss_valid = 1'b1;
      miss_addr  = addr;
      miss_way   = way;
      tick(tog);
      miss_valid = 1'b0;
      check("req_valid",      req_valid,  1);
      check("req_addr",       req_addr,   exp_req);
      check("req_miss_ready", miss_ready, 0);
      for (int i = 0; i < stall; i++) begin
         tick(tog);
         check("req_hold_valid", req_valid, 1);
         check("req_hold_addr",  req_addr,  exp_req);
      end
      req_ready = 1'b1;
      tick(tog);
      req_ready = 1'b0;
      check("fill_req_dropped", req_valid, 0);
      for (int k = 0; k < 4; k++) begin
         for (int g = 0; g < gap; g++) begin
            tick(tog);
            check("gap_no_wr", wr_en, 0);
         end
         rsp_valid = 1'b1;
         rsp_data  = beats[k];
         flush     = (k == flush_beat);
         tick(tog);
         rsp_valid = 1'b0;
         rsp_data  = {$urandom, $urandom};
         flush     = 1'b0;
         if (k < 3) begin
            check("beat_no_wr",    wr_en,       0);
            check("beat_no_done",  refill_done, 0);
            check("beat_no_ready", miss_ready,  0);
         end
      end
      if (!flushed) begin
         check("wr_en",        wr_en,       1);
         check("refill_done",  refill_done, 1);
         check("write_ready",  miss_ready,  0);
         check("wr_idx",       wr_idx,      exp_idx);
         check("wr_tag",       wr_tag,      exp_tag);
         check("wr_way",       wr_way,      way);
         check("wr_data",      wr_data,     exp_line);
         tick(tog);
         check("post_wr_en",   wr_en,       0);
         check("post_done",    refill_done, 0);
      end else begin
         check("flushed_no_wr",   wr_en,       0);
         check("flushed_no_done", refill_done, 0);
      end
      check("return_ready",     miss_ready, 1);
      check("return_req_valid", req_valid,  0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [31:0]      a;
      logic [3:0][63:0] bts;
      int               fb;

      tog_seq[0] = 2'd2;
      tog_seq[1] = 2'd1;
      tog_seq[2] = 2'd3;

      vecs[0] = '{32'h0000_1234, 2'd2, {64'h44, 64'h33, 64'h22, 64'h11}, 0, 0, -1, 1'b0,
                  32'h0000_1220, 8'h91, 19'h0};
      vecs[1] = '{32'h0000_1234, 2'd2, {64'hA4, 64'hA3, 64'hA2, 64'hA1}, 0, 0, -1, 1'b1,
                  32'h0000_1220, 8'h91, 19'h0};
      vecs[2] = '{32'h8000_2000, 2'd0, {64'hDEAD_0003, 64'hDEAD_0002, 64'hDEAD_0001, 64'hDEAD_0000},
                  3, 1, -1, 1'b0, 32'h8000_2000, 8'h00, 19'h40001};
      vecs[3] = '{32'h0000_1234, 2'd2, {64'h4, 64'h3, 64'h2, 64'h1}, 0, 0, 2, 1'b0,
                  32'h0000_1220, 8'h91, 19'h0};
      vecs[4] = '{32'hFFFF_FFFF, 2'd3, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h5555, 64'hAAAA},
                  1, 0, -1, 1'b0, 32'hFFFF_FFE0, 8'hFF, 19'h7FFFF};
      vecs[5] = '{32'h1234_567F, 2'd1, {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                  64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888}, 0, 2, -1, 1'b0,
                  32'h1234_5660, 8'hB3, 19'h091A2};

      rst        = 1'b1;
      miss_valid = 1'b0;
      miss_addr  = '0;
      miss_way   = '0;
      flush      = 1'b0;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      rsp_data   = '0;
      tick(1'b0);
      tick(1'b0);
      check_reset_outputs("reset");
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         do_refill(vecs[i].addr, vecs[i].way, vecs[i].beats, vecs[i].stall, vecs[i].gap,
                   vecs[i].flush_beat, vecs[i].tog, vecs[i].exp_req, vecs[i].exp_idx,
                   vecs[i].exp_tag);
      end

      // Flush in REQ without acknowledge: no request issued, idle next cycle.
      accept_miss(32'h0000_4000, 2'd1);
      flush = 1'b1;
      tick(1'b0);
      flush = 1'b0;
      check("reqflush_ready",     miss_ready, 1);
      check("reqflush_req_valid", req_valid,  0);
      check("reqflush_no_wr",     wr_en,      0);

      // Flush coincident with acknowledge: request is outstanding, all four beats drained.
      accept_miss(32'h0000_5000, 2'd3);
      flush     = 1'b1;
      req_ready = 1'b1;
      tick(1'b0);
      flush     = 1'b0;
      req_ready = 1'b0;
      check("ackflush_req_valid", req_valid,  0);
      check("ackflush_ready",     miss_ready, 0);
      drain_beats(4, "ackflush");

      // Flush in FILL before any beat arrives.
      accept_miss(32'h0000_6000, 2'd0);
      req_ready = 1'b1;
      tick(1'b0);
      req_ready = 1'b0;
      flush = 1'b1;
      tick(1'b0);
      flush = 1'b0;
      check("fillflush_ready", miss_ready, 0);
      drain_beats(4, "fillflush");

      // Reset in FILL after two beats.
      accept_miss(32'h0000_ABC0, 2'd3);
      req_ready = 1'b1;
      tick(1'b0);
      req_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         rsp_valid = 1'b1;
         rsp_data  = {$urandom, $urandom};
         tick(1'b0);
         rsp_valid = 1'b0;
      end
      rst = 1'b1;
      tick(1'b0);
      rst = 1'b0;
      check_reset_outputs("midreset");

      do_refill(vecs[0].addr, vecs[0].way, vecs[0].beats, 0, 0, -1, 1'b0,
                vecs[0].exp_req, vecs[0].exp_idx, vecs[0].exp_tag);

      // Randomized refills with expectations from address arithmetic.
      for (int n = 0; n < 40; n++) begin
         a   = $urandom;
         bts = {{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}};
         fb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
         do_refill(a, 2'($urandom), bts, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                   fb, 1'b0, a - (a % 32), 8'((a / 32) % 256), 19'(a / 8192));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
